// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
//   Shared types and helpers for the decode / register-read stage.
//   - imm_sel_t : which immediate field of the raw instruction bits is used.
//   - ext_imm   : sign/zero-extends the selected field to a caller-given width.
//                 The result is EXT_MAX_W bits wide. The caller keeps the low
//                 data_w bits. Bits at and above data_w come back as zero.
// -----------------------------------------------------------------------------
package decode_pkg;

  // Width of the raw immediate bits taken from the instruction (instr[10:0]).
  localparam int IMM_RAW_W = 11;

  // Widest data path the extension helper supports.
  localparam int EXT_MAX_W = 64;

  typedef enum logic [1:0] {
    IMM5  = 2'd0,
    IMM8  = 2'd1,
    IMM11 = 2'd2,
    NONE  = 2'd3
  } imm_sel_t;

  // Extend the selected immediate field. A field of width F occupies bits
  // [F-1:0]. Bits from F up to data_w-1 are filled with the field MSB when
  // sext=1, otherwise with 0.
  function automatic logic [EXT_MAX_W-1:0] ext_imm(
    input logic [IMM_RAW_W-1:0] raw,
    input imm_sel_t             sel,
    input logic                 sext,
    input int                   data_w
  );
    logic [EXT_MAX_W-1:0] res;
    logic [EXT_MAX_W-1:0] raw_ext;
    logic [3:0]           field_w;
    logic                 fill;
    res     = '0;
    raw_ext = {{(EXT_MAX_W-IMM_RAW_W){1'b0}}, raw};
    case (sel)
      IMM5: begin
        field_w = 4'd5;
        fill    = sext & raw[4];
      end
      IMM8: begin
        field_w = 4'd8;
        fill    = sext & raw[7];
      end
      IMM11: begin
        field_w = 4'd11;
        fill    = sext & raw[10];
      end
      default: begin
        field_w = 4'd0;
        fill    = 1'b0;
      end
    endcase
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i >= data_w) begin
        res[i] = 1'b0;
      end else if (i < int'(field_w)) begin
        res[i] = raw_ext[i];
      end else begin
        res[i] = fill;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_sb_stage_regfile_bp.sv
// -----------------------------------------------------------------------------
// regfile_bp
//   Register file with two read ports, one write port and an optional
//   write-before-read bypass.
//   Ports:
//     clk, rst_n        : clock (rising edge) and async active-low reset
//     i_we/i_waddr/i_wdata : write port, applied on the clock edge
//     i_raddr1/i_raddr2 : read addresses (combinational read)
//     o_rdata1/o_rdata2 : read data. When BYPASS=1, a same-cycle write to the
//                         read address is forwarded.
// -----------------------------------------------------------------------------
module regfile_bp #(
  parameter int  DATA_W   = 16,
  parameter int  NUM_REGS = 8,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_fwd1;
  logic              w_fwd2;

  // Storage: cleared on reset, one write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports. Forward the incoming write when the bypass is built in.
  always_comb begin
    w_fwd1 = BYPASS && i_we && (i_waddr == i_raddr1);
    w_fwd2 = BYPASS && i_we && (i_waddr == i_raddr2);
    if (w_fwd1) begin
      o_rdata1 = i_wdata;
    end else begin
      o_rdata1 = r_regs[i_raddr1];
    end
    if (w_fwd2) begin
      o_rdata2 = i_wdata;
    end else begin
      o_rdata2 = r_regs[i_raddr2];
    end
  end

endmodule

// File: rtl/decode_sb_stage.sv
// -----------------------------------------------------------------------------
// decode_sb_stage
//   Decode / register-read stage between fetch and execute.
//   - Reads two operands from the register file, which has a write-before-read
//     bypass.
//   - Extends the selected immediate.
//   - Stalls RAW/WAW hazards against in-flight writers using a pending-write
//     scoreboard.
//   - Presents the result in a registered ID/EX slot with a valid/ready
//     handshake and a flush.
//   Ports:
//     clk, rst     : clock (rising edge) and async active-low reset
//     in_*         : upstream instruction and its handshake (in_valid/in_ready)
//     wb_*         : writeback port into the register file
//     flush        : kills the ID/EX slot and refuses the current input
//     out_*        : registered ID/EX slot and its handshake (out_valid/out_ready)
//     stall        : a hazard is holding the input this cycle
// -----------------------------------------------------------------------------
module decode_sb_stage
  import decode_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  NUM_REGS = 8,
  parameter int  CTRL_W   = 24,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic              in_rs1_used,
  input  logic              in_rs2_used,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_rd_we,
  input  logic [10:0]       in_imm_raw,
  input  logic [1:0]        in_imm_sel,
  input  logic              in_sext,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_num,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r1,
  output logic [DATA_W-1:0] out_r2,
  output logic [DATA_W-1:0] out_imm,
  output logic [AW-1:0]     out_rs1,
  output logic [AW-1:0]     out_rs2,
  output logic [AW-1:0]     out_rd,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              stall
);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;

  regfile_bp #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst),
    .i_we     (wb_en),
    .i_waddr  (wb_num),
    .i_wdata  (wb_data),
    .i_raddr1 (in_rs1),
    .i_raddr2 (in_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // ---------------------------------------------------------------------------
  // Immediate extension
  // ---------------------------------------------------------------------------
  logic [EXT_MAX_W-1:0]        w_imm_full;
  logic [DATA_W-1:0]           w_imm;
  logic [EXT_MAX_W-DATA_W-1:0] w_imm_unused;

  // The helper works at its widest size. Only the low DATA_W bits are kept.
  always_comb begin
    w_imm_full = ext_imm(in_imm_raw, imm_sel_t'(in_imm_sel), in_sext, DATA_W);
  end

  assign w_imm        = w_imm_full[DATA_W-1:0];
  assign w_imm_unused = w_imm_full[EXT_MAX_W-1:DATA_W];

  // ---------------------------------------------------------------------------
  // Hazard detection and handshake
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_wb_clr_rs1;
  logic                w_wb_clr_rs2;
  logic                w_wb_clr_rd;
  logic                w_haz1;
  logic                w_haz2;
  logic                w_hazw;
  logic                w_stall;
  logic                w_in_ready;
  logic                w_accept;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_r1;
  logic [DATA_W-1:0]   r_out_r2;
  logic [DATA_W-1:0]   r_out_imm;
  logic [AW-1:0]       r_out_rs1;
  logic [AW-1:0]       r_out_rs2;
  logic [AW-1:0]       r_out_rd;
  logic                r_out_rd_we;
  logic [CTRL_W-1:0]   r_out_ctrl;

  // Hazards against pending writers. A same-cycle writeback only resolves a
  // hazard when its data reaches the read port through the bypass. Without the
  // bypass, the reader waits one more cycle for the register-file copy.
  always_comb begin
    w_wb_clr_rs1 = BYPASS && wb_en && (wb_num == in_rs1);
    w_wb_clr_rs2 = BYPASS && wb_en && (wb_num == in_rs2);
    w_wb_clr_rd  = BYPASS && wb_en && (wb_num == in_rd);
    w_haz1       = in_rs1_used && r_pending[in_rs1] && !w_wb_clr_rs1;
    w_haz2       = in_rs2_used && r_pending[in_rs2] && !w_wb_clr_rs2;
    w_hazw       = in_rd_we && r_pending[in_rd] && !w_wb_clr_rd;
    // Reset gating keeps both handshake outputs low while rst is held.
    w_stall      = rst && in_valid && (w_haz1 || w_haz2 || w_hazw);
    w_in_ready   = rst && !w_stall && !flush && (!r_out_valid || out_ready);
    w_accept     = in_valid && w_in_ready;
  end

  assign stall    = w_stall;
  assign in_ready = w_in_ready;

  // ---------------------------------------------------------------------------
  // Scoreboard update
  // ---------------------------------------------------------------------------

  // Next pending bits. A new writer's set wins over any clear. A flushed writer
  // in the slot will never write back, so its bit is released here.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (w_accept && in_rd_we && (in_rd == AW'(r))) begin
        w_pending_nxt[r] = 1'b1;
      end else if (wb_en && (wb_num == AW'(r))) begin
        w_pending_nxt[r] = 1'b0;
      end else if (flush && r_out_valid && r_out_rd_we && (r_out_rd == AW'(r))) begin
        w_pending_nxt[r] = 1'b0;
      end else begin
        w_pending_nxt[r] = r_pending[r];
      end
    end
  end

  // Pending-write bits, one per architectural register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX output slot
  // ---------------------------------------------------------------------------

  // ID/EX slot. Data only changes on accept. While the slot is stalled, the
  // captured operands stay frozen even if a later writeback hits the register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_r1    <= '0;
      r_out_r2    <= '0;
      r_out_imm   <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_rd    <= '0;
      r_out_rd_we <= 1'b0;
      r_out_ctrl  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_r1    <= w_rdata1;
      r_out_r2    <= w_rdata2;
      r_out_imm   <= w_imm;
      r_out_rs1   <= in_rs1;
      r_out_rs2   <= in_rs2;
      r_out_rd    <= in_rd;
      r_out_rd_we <= in_rd_we;
      r_out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_r1    = r_out_r1;
  assign out_r2    = r_out_r2;
  assign out_imm   = r_out_imm;
  assign out_rs1   = r_out_rs1;
  assign out_rs2   = r_out_rs2;
  assign out_rd    = r_out_rd;
  assign out_rd_we = r_out_rd_we;
  assign out_ctrl  = r_out_ctrl;

endmodule

// File: tb/tb_decode_sb_stage.sv
// Self-checking bench for decode_sb_stage at default parameters
// (DATA_W=16, NUM_REGS=8, CTRL_W=24, BYPASS=1).
module tb_decode_sb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rs1;
  logic [2:0]  in_rs2;
  logic        in_rs1_used;
  logic        in_rs2_used;
  logic [2:0]  in_rd;
  logic        in_rd_we;
  logic [10:0] in_imm_raw;
  logic [1:0]  in_imm_sel;
  logic        in_sext;
  logic [23:0] in_ctrl;
  logic        wb_en;
  logic [2:0]  wb_num;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r1;
  logic [15:0] out_r2;
  logic [15:0] out_imm;
  logic [2:0]  out_rs1;
  logic [2:0]  out_rs2;
  logic [2:0]  out_rd;
  logic        out_rd_we;
  logic [23:0] out_ctrl;
  logic        stall;

  decode_sb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_imm_raw(in_imm_raw), .in_imm_sel(in_imm_sel), .in_sext(in_sext),
    .in_ctrl(in_ctrl),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r1(out_r1), .out_r2(out_r2), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_ctrl(out_ctrl),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] imm;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic        rd_we;
    logic [23:0] ctrl;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model_regs [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference register file, with the same reset and write timing as the architecture.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) model_regs[i] <= 16'h0000;
    end else if (wb_en) begin
      model_regs[wb_num] <= wb_data;
    end
  end

  function automatic logic [15:0] model_read(input logic [2:0] rs);
    if (wb_en && wb_num == rs) return wb_data;
    return model_regs[rs];
  endfunction

  function automatic logic [15:0] ref_imm(input logic [10:0] raw, input logic [1:0] sel, input logic sx);
    case (sel)
      2'd0:    return (sx && raw[4])  ? {11'h7FF, raw[4:0]}  : {11'h000, raw[4:0]};
      2'd1:    return (sx && raw[7])  ? {8'hFF, raw[7:0]}    : {8'h00, raw[7:0]};
      2'd2:    return (sx && raw[10]) ? {5'h1F, raw[10:0]}   : {5'h00, raw[10:0]};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_expected();
    exp_t e;
    e.r1    = model_read(in_rs1);
    e.r2    = model_read(in_rs2);
    e.imm   = ref_imm(in_imm_raw, in_imm_sel, in_sext);
    e.rs1   = in_rs1;
    e.rs2   = in_rs2;
    e.rd    = in_rd;
    e.rd_we = in_rd_we;
    e.ctrl  = in_ctrl;
    sb_q.push_back(e);
  endtask

  task automatic drive_instr(input logic [2:0] rs1, input logic u1, input logic [2:0] rs2,
                             input logic u2, input logic [2:0] rd, input logic we,
                             input logic [10:0] raw, input logic [1:0] sel, input logic sx);
    in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
    in_rd = rd; in_rd_we = we; in_imm_raw = raw; in_imm_sel = sel; in_sext = sx;
    in_ctrl = 24'($urandom);
    in_valid = 1'b1;
  endtask

  // Holds the driven instruction until it is accepted, within a cycle budget.
  task automatic accept_one(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_expected();
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    check_eq({tag, "_accept"}, 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  // Scoreboard consumer: one entry per downstream handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      bit   have;
      exp_t e;
      have = (sb_q.size() != 0);
      check_eq("sb_nonempty", 32'(have), 32'd1);
      if (have) begin
        e = sb_q.pop_front();
        check_eq("sb_r1",    32'(out_r1),    32'(e.r1));
        check_eq("sb_r2",    32'(out_r2),    32'(e.r2));
        check_eq("sb_imm",   32'(out_imm),   32'(e.imm));
        check_eq("sb_rs1",   32'(out_rs1),   32'(e.rs1));
        check_eq("sb_rs2",   32'(out_rs2),   32'(e.rs2));
        check_eq("sb_rd",    32'(out_rd),    32'(e.rd));
        check_eq("sb_rd_we", 32'(out_rd_we), 32'(e.rd_we));
        check_eq("sb_ctrl",  32'(out_ctrl),  32'(e.ctrl));
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_rs1 = 3'd0; in_rs2 = 3'd0; in_rs1_used = 1'b0;
    in_rs2_used = 1'b0; in_rd = 3'd0; in_rd_we = 1'b0; in_imm_raw = 11'd0;
    in_imm_sel = 2'd3; in_sext = 1'b0; in_ctrl = 24'd0; wb_en = 1'b0; wb_num = 3'd0;
    wb_data = 16'd0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  32'(in_ready),  32'd0);
    check_eq("rst_stall",     32'(stall),     32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_r1",    32'(out_r1),    32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    // Fill r3 and read it with an IMM8 immediate.
    wb_en = 1'b1; wb_num = 3'd3; wb_data = 16'h1234;
    @(posedge clk); #1;
    wb_en = 1'b0;
    drive_instr(3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 11'h0F0, 2'd1, 1'b1);
    accept_one("fill", 1);
    @(negedge clk);
    check_eq("fill_valid", 32'(out_valid), 32'd1);
    check_eq("fill_r1",    32'(out_r1),    32'h1234);
    check_eq("fill_imm",   32'(out_imm),   32'hFFF0);
    @(posedge clk); #1;
    // RAW: a writer to r2, then a reader of r2 stalls until the writeback.
    drive_instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 11'h7FF, 2'd2, 1'b0);
    accept_one("raw_wr", 1);
    drive_instr(3'd1, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 11'h010, 2'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("raw_stall", 32'(stall),    32'd1);
      check_eq("raw_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    wb_en = 1'b1; wb_num = 3'd2; wb_data = 16'hBEEF;
    accept_one("raw_rd", 1);
    wb_en = 1'b0;
    @(negedge clk);
    check_eq("raw_r2", 32'(out_r2), 32'hBEEF);
    @(posedge clk); #1;
    // Same-cycle set and clear on r5.
    drive_instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 11'h000, 2'd3, 1'b0);
    accept_one("sc_wr1", 1);
    drive_instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 11'h3AA, 2'd1, 1'b0);
    wb_en = 1'b1; wb_num = 3'd5; wb_data = 16'h5A5A;
    accept_one("sc_wr2", 1);
    wb_en = 1'b0;
    drive_instr(3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 11'h400, 2'd2, 1'b1);
    @(negedge clk);
    check_eq("sc_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    wb_en = 1'b1; wb_num = 3'd5; wb_data = 16'h0055;
    accept_one("sc_rd", 1);
    wb_en = 1'b0;
    // Backpressure: slot frozen for three cycles, a writeback must not refresh it.
    drive_instr(3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 11'h01F, 2'd0, 1'b1);
    accept_one("bp_a", 1);
    out_ready = 1'b0;
    drive_instr(3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 11'h080, 2'd1, 1'b0);
    wb_en = 1'b1; wb_num = 3'd3; wb_data = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_ready", 32'(in_ready),  32'd0);
      check_eq("bp_r1",    32'(out_r1),    32'h1234);
      check_eq("bp_imm",   32'(out_imm),   32'hFFFF);
      @(posedge clk); #1;
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    accept_one("bp_b", 1);
    // Flush a writer of r4 held in the slot; the reader of r4 then proceeds.
    drive_instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 11'h155, 2'd2, 1'b1);
    accept_one("fl_wr", 1);
    out_ready = 1'b0;
    drive_instr(3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 11'h00F, 2'd0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check_eq("fl_ready", 32'(in_ready), 32'd0);
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("fl_valid", 32'(out_valid), 32'd0);
    accept_one("fl_rd", 1);
    out_ready = 1'b1;
    // Flush alone blocks a hazard-free input.
    drive_instr(3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 11'h2C3, 2'd2, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    check_eq("fl2_ready", 32'(in_ready), 32'd0);
    check_eq("fl2_stall", 32'(stall),    32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("fl2_valid", 32'(out_valid), 32'd0);
    accept_one("fl2_in", 1);
    // Asynchronous reset while a reader of r6 is stalled.
    drive_instr(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 11'h001, 2'd0, 1'b0);
    accept_one("ar_wr", 1);
    drive_instr(3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 11'h0AA, 2'd1, 1'b0);
    @(negedge clk);
    check_eq("ar_stall_pre", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("ar_valid", 32'(out_valid), 32'd0);
    check_eq("ar_stall", 32'(stall),     32'd0);
    check_eq("ar_ready", 32'(in_ready),  32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    accept_one("ar_rd6", 1);
    drive_instr(3'd3, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 11'h000, 2'd3, 1'b1);
    accept_one("ar_rd3", 1);
    @(negedge clk);
    check_eq("ar_r3", 32'(out_r1), 32'd0);
    @(posedge clk); #1;
    // Back-to-back hazard-free stream with random writebacks alongside.
    for (int n = 0; n < 16; n++) begin
      wb_en = 1'($urandom); wb_num = 3'($urandom); wb_data = 16'($urandom);
      drive_instr(3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
                  1'b0, 11'($urandom), 2'($urandom), 1'($urandom));
      accept_one("thru", 1);
    end
    wb_en = 1'b0;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check_eq("drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
